// File: rtl/turn_signal_conditioner_pkg.sv
// Shared constants for the turn-signal input conditioner and the tail-light sequencer.
// Debounce and step periods are derived from the system clock frequency.
package turn_signal_conditioner_pkg;

  localparam int unsigned CLK_FREQ_HZ  = 50_000_000;
  localparam int unsigned DEBOUNCE_MS  = 5;
  localparam int unsigned STEP_RATE_HZ = 4;

  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned DEFAULT_TICK_CYCLES     = CLK_FREQ_HZ / STEP_RATE_HZ;

  typedef struct packed {
    logic left;
    logic right;
  } request_t;

  // A request is only honoured while the opposite button is not also held.
  function automatic request_t exclusive_request(input logic db_l, input logic db_r);
    request_t req;
    req.left  = db_l & ~db_r;
    req.right = db_r & ~db_l;
    return req;
  endfunction

endpackage

// File: rtl/turn_signal_conditioner_debounce_channel.sv
// One button channel: two-flop synchroniser followed by a consecutive-cycle debouncer.
// The stable level flips only after DEBOUNCE_CYCLES back-to-back disagreeing edges.
module debounce_channel
  import turn_signal_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic db
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // NOTE: all state updates use non-blocking assignments so s1->s2->db sample
  // the previous-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1  <= 1'b0;
      s2  <= 1'b0;
      db  <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      if (s2 == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/turn_signal_conditioner.sv
// Conditions raw left/right turn buttons into exclusive levels, press pulses and
// a step_tick that paces the downstream tail-light sequencer.
module turn_signal_conditioner
  import turn_signal_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned TICK_CYCLES     = DEFAULT_TICK_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_left_raw,
  input  logic btn_right_raw,
  output logic left,
  output logic right,
  output logic left_press,
  output logic right_press,
  output logic step_tick
);

  localparam int unsigned      TCNT_W    = $clog2(TICK_CYCLES);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TICK_CYCLES - 1);

  logic              db_l;
  logic              db_r;
  logic              left_q;
  logic              right_q;
  logic [TCNT_W-1:0] tcnt;
  request_t          req;
  logic              any_press;

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_left (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_left_raw),
    .db      (db_l)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_right (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_right_raw),
    .db      (db_r)
  );

  assign req         = exclusive_request(db_l, db_r);
  assign left        = req.left;
  assign right       = req.right;
  assign left_press  = left & ~left_q;
  assign right_press = right & ~right_q;
  assign any_press   = left_press | right_press;

  // A press wins over a coincident tick and restarts the period, so the
  // sequencer's first step lands a full period after the press.
  assign step_tick = (tcnt == TCNT_LAST) & ~any_press;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      tcnt    <= '0;
    end else begin
      left_q  <= left;
      right_q <= right;
      if (any_press || tcnt == TCNT_LAST) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + TCNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_turn_signal_conditioner.sv
// Directed bench for turn_signal_conditioner with DEBOUNCE_CYCLES=4, TICK_CYCLES=8.
// Outputs are sampled 1 ns after each rising edge; edge 1 is the first edge after reset release.
module tb_turn_signal_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic btn_left_raw;
  logic btn_right_raw;
  logic left, right, left_press, right_press, step_tick;
  logic [4:0] obs;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  turn_signal_conditioner #(.DEBOUNCE_CYCLES(4), .TICK_CYCLES(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_left_raw  (btn_left_raw),
    .btn_right_raw (btn_right_raw),
    .left          (left),
    .right         (right),
    .left_press    (left_press),
    .right_press   (right_press),
    .step_tick     (step_tick)
  );

  // {left, right, left_press, right_press, step_tick}
  assign obs = {left, right, left_press, right_press, step_tick};

  typedef struct {
    logic       bl;
    logic       br;
    int         n;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic bl, input logic br);
    reset         = 1'b0;
    btn_left_raw  = bl;
    btn_right_raw = br;
    #1;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 5, 5'b00000};
    vecs[1]  = '{1'b1, 1'b0, 1, 5'b10100};
    vecs[2]  = '{1'b1, 1'b0, 2, 5'b10000};
    vecs[3]  = '{1'b0, 1'b0, 5, 5'b10000};
    vecs[4]  = '{1'b0, 1'b0, 1, 5'b00001};
    vecs[5]  = '{1'b0, 1'b0, 1, 5'b00000};
    vecs[6]  = '{1'b0, 1'b1, 5, 5'b00000};
    vecs[7]  = '{1'b0, 1'b1, 1, 5'b01010};
    vecs[8]  = '{1'b0, 1'b1, 2, 5'b01000};
    vecs[9]  = '{1'b1, 1'b1, 5, 5'b01000};
    vecs[10] = '{1'b1, 1'b1, 1, 5'b00001};
    vecs[11] = '{1'b1, 1'b1, 1, 5'b00000};
    vecs[12] = '{1'b1, 1'b0, 5, 5'b00000};
    vecs[13] = '{1'b1, 1'b0, 1, 5'b10100};
    vecs[14] = '{1'b1, 1'b0, 1, 5'b10000};
    vecs[15] = '{1'b0, 1'b1, 5, 5'b10000};
    vecs[16] = '{1'b0, 1'b1, 1, 5'b01010};
    vecs[17] = '{1'b0, 1'b1, 7, 5'b01000};
    vecs[18] = '{1'b0, 1'b1, 1, 5'b01001};
    vecs[19] = '{1'b0, 1'b1, 1, 5'b01000};

    // Reset hold with both buttons pressed.
    reset         = 1'b0;
    btn_left_raw  = 1'b1;
    btn_right_raw = 1'b1;
    #1;
    check("reset_outputs_async", 32'(obs), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_outputs_held", 32'(obs), 32'd0);
    end
    check("reset_db_l_held", 32'(dut.u_left.db), 32'd0);
    reset = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      check("both_held_outputs", 32'(obs), 32'd0);
    end
    check("both_held_db_l", 32'(dut.u_left.db), 32'd1);
    check("both_held_db_r", 32'(dut.u_right.db), 32'd1);

    // Table: clean press/release, exclusion, release-raises-held, swap, ticks.
    do_reset(1'b0, 1'b0);
    for (int v = 0; v < 20; v++) begin
      btn_left_raw  = vecs[v].bl;
      btn_right_raw = vecs[v].br;
      for (int c = 0; c < vecs[v].n; c++) begin
        step();
        check($sformatf("vec%0d_cyc%0d", v, c), 32'(obs), 32'(vecs[v].exp));
      end
    end

    // Bounce rejection: 3-cycle phases never qualify, then a steady level does.
    do_reset(1'b0, 1'b0);
    for (int c = 0; c < 40; c++) begin
      btn_left_raw = ((c / 3) % 2 == 0) ? 1'b1 : 1'b0;
      step();
      check("bounce_left_low", 32'(left), 32'd0);
    end
    btn_left_raw = 1'b1;
    step();
    for (int e = 1; e <= 5; e++) begin
      step();
      check("bounce_settle_left", 32'(left), (e == 5) ? 32'd1 : 32'd0);
      check("bounce_settle_press", 32'(left_press), (e == 5) ? 32'd1 : 32'd0);
    end

    // Tick cadence without presses.
    do_reset(1'b0, 1'b0);
    for (int n = 1; n <= 24; n++) begin
      step();
      check($sformatf("tick_cadence_e%0d", n), 32'(step_tick), (n % 8 == 7) ? 32'd1 : 32'd0);
    end

    // Right press lands on tcnt==7: press suppresses the tick and restarts the period.
    do_reset(1'b0, 1'b0);
    for (int n = 1; n <= 24; n++) begin
      if (n == 10) btn_right_raw = 1'b1;
      step();
      check($sformatf("collide_tick_e%0d", n), 32'(step_tick),
            (n == 7 || n == 23) ? 32'd1 : 32'd0);
      check($sformatf("collide_rpress_e%0d", n), 32'(right_press), (n == 15) ? 32'd1 : 32'd0);
    end

    // Reset in the middle of a left qualification.
    do_reset(1'b0, 1'b0);
    btn_left_raw = 1'b1;
    for (int n = 1; n <= 5; n++) step();
    check("middeb_cnt_before", 32'(dut.u_left.cnt), 32'd3);
    check("middeb_left_before", 32'(left), 32'd0);
    reset = 1'b0;
    #1;
    check("middeb_outputs", 32'(obs), 32'd0);
    check("middeb_cnt", 32'(dut.u_left.cnt), 32'd0);
    check("middeb_s2", 32'(dut.u_left.s2), 32'd0);
    check("middeb_tcnt", 32'(dut.tcnt), 32'd0);
    step();
    check("middeb_outputs_held", 32'(obs), 32'd0);
    reset = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      step();
      check($sformatf("requal_left_e%0d", n), 32'(left), (n == 6) ? 32'd1 : 32'd0);
    end
    check("requal_press", 32'(left_press), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/turn_signal_conditioner.md
# turn_signal_conditioner

Input-conditioning stage directly upstream of the tail-light sequencer FSM. It synchronises and debounces the raw left/right turn-signal buttons and makes the two requests mutually exclusive. It emits level requests, one-cycle press pulses, and a slow `step_tick` that paces the sequencer's light-state advances. Its outputs connect straight to the sequencer's `left`/`right` inputs and its step enable.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000. Consecutive stable cycles required to accept a new level (5 ms at 50 MHz). Legal range ≥ 1.
- `TICK_CYCLES`, default 12500000. Period of `step_tick` in clocks (4 Hz at 50 MHz). Legal range ≥ 2.

Ports:
- `clk` in 1: single system clock, rising edge.
- `reset` in 1: asynchronous, active-low. Low clears all state immediately.
- `btn_left_raw` in 1: asynchronous raw left button, active-high.
- `btn_right_raw` in 1: asynchronous raw right button, active-high.
- `left` out 1: debounced, exclusive left request level.
- `right` out 1: debounced, exclusive right request level.
- `left_press` out 1: one-cycle pulse on the rising edge of `left`.
- `right_press` out 1: one-cycle pulse on the rising edge of `right`.
- `step_tick` out 1: one-cycle pacing pulse.

## Operation
- **Synchroniser:** two-flop chain per button, `s1` then `s2`. Reset value 0.
- **Debounce**, per channel, with stable register `db` (reset 0) and counter `cnt` (reset 0, width `$clog2(DEBOUNCE_CYCLES+1)`):
  - `s2 == db`: `cnt <= 0`.
  - `s2 != db` and `cnt == DEBOUNCE_CYCLES-1`: `db <= s2`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
  - Net effect: any single-cycle agreement restarts the count, and `db` flips on the N-th consecutive disagreeing edge.
- **Exclusion:** `left = db_l & ~db_r` and `right = db_r & ~db_l`.
  - Both held gives both outputs 0.
  - Releasing one button while the other stays held raises the held side's output in the same cycle the released side's `db` falls.
- **Press pulses:** registered previous values `left_q`/`right_q` (reset 0).
  - `left_press = left & ~left_q`.
  - `right_press = right & ~right_q`.
  - A `left` to `right` swap in one cycle gives `right_press = 1` and `left_press = 0`.
- **Tick counter** `tcnt` (reset 0, width `$clog2(TICK_CYCLES)`):
  - Free-running from 0 to `TICK_CYCLES-1`, then wraps to 0.
  - `step_tick = (tcnt == TICK_CYCLES-1) & ~(left_press | right_press)`.
  - On any press pulse, `tcnt <= 0`, so the first sequencer step follows a full period after the press. Press beats tick when they coincide.
- **Reset mid-operation:** all counters, `db`, synchroniser and `_q` flops clear asynchronously. A held button after release must re-qualify for the full debounce time.
- **Outputs during reset:** all outputs are 0.

## Timing
- Edge k is the first edge at which `s1` samples a new raw level.
  - `s2` follows at edge k+1.
  - `db` and `left`/`right` change at edge k+1+`DEBOUNCE_CYCLES`.
  - The press pulse is high for the cycle following that edge.
- No combinational path from raw inputs to any output. `left`, `right`, `*_press` and `step_tick` are combinational only from local flops.
- **After reset release:**
  - The first `step_tick` is high in the cycle after the (`TICK_CYCLES`-1)-th edge.
  - Ticks then repeat every `TICK_CYCLES` cycles, exactly one cycle wide.
  - This holds unless a press restarts the count.
- Reset deassertion is assumed synchronised externally. The block only guarantees asynchronous assertion.

## Structure
- The shared package holds:
  - the system clock frequency constant;
  - default `DEBOUNCE_CYCLES` and `TICK_CYCLES` derived from it;
  - the step-rate constant shared with the sequencer.
- One natural sub-module, `debounce_channel`, instantiated twice. It contains the synchroniser, `db` and `cnt`, and is parameterised by `DEBOUNCE_CYCLES`.
- Exclusion, press detection and the tick counter live in the top level.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4` and `TICK_CYCLES=8`.
1. **Reset hold:** `reset` low, both raw inputs 1 → all outputs 0. Release; 6 edges later both `db` are 1, yet `left=right=0` and no press pulses.
2. **Clean left press:** `btn_left_raw` 0→1, first sampled at edge 0 → `left` rises after edge 5. `left_press` is high for exactly one cycle. `right` and `right_press` stay 0. Release gives `left` 0 after edge 5 relative to the release.
3. **Bounce rejection:** raw left toggles every 3 cycles for 40 cycles → `left` never rises. It then holds 1 → `left` rises exactly 5 edges after the last toggle is sampled.
4. **Tick cadence, no presses:** `step_tick` pulses at cycles 7, 15, 23 after release, each exactly 1 cycle wide.
5. **Press collides with tick:** `right_press` lands in the cycle with `tcnt==7` → `step_tick` is 0 that cycle. The next `step_tick` occurs 8 cycles later.
6. **Reset mid-debounce:** assert `reset` when the left `cnt==3` → all outputs and counters are 0 immediately. Release with the button held → `left` rises only after the full 6-edge qualification.
